// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler
// Shares one VGA write port between NUM_REQ drawing engines. Each engine is
// held in reset (run=0) until it is granted. The granted engine's pixel stream
// is registered onto the vga_* outputs until the engine raises its sticky done
// flag, or until the watchdog expires. Engines are granted round-robin.
//
// Ports
//   clk, resetn        clock; synchronous active-low reset
//   req[N]             level request per engine, held until serviced
//   done[N]            sticky done flag per engine, cleared by run going low
//   plot_in/x_in/y_in/colour_in   per-engine pixel stream, packed by engine
//   run[N]             per-engine active-low reset, at most one bit high
//   done_ack[N]        one-cycle pulse on normal completion
//   timeout_err        one-cycle pulse when the watchdog aborts an engine
//   vga_x/y/colour/plot  registered muxed pixel stream
//   busy               high whenever the FSM is not idle
//   grant_id           current or last granted engine
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no owner; round-robin search of req starting at rr_ptr
// S_START   | engine's first cycle out of reset; its done flag may be stale
// S_DRAW    | pixel stream muxed to VGA; wait for done or watchdog
// S_RELEASE | run held low so the engine's sticky done clears
module vga_draw_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CW             = 9
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     done,
    input  logic [NUM_REQ-1:0]     plot_in,
    input  logic [8*NUM_REQ-1:0]   x_in,
    input  logic [7*NUM_REQ-1:0]   y_in,
    input  logic [CW*NUM_REQ-1:0]  colour_in,
    output logic [NUM_REQ-1:0]     run,
    output logic [NUM_REQ-1:0]     done_ack,
    output logic                   timeout_err,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [CW-1:0]          vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    // One spare count value so the increment never wraps before the compare.
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_DRAW    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              r_state,  w_state_nxt;
    logic [2:0]          r_rr_ptr, w_rr_nxt;
    logic [2:0]          r_grant,  w_grant_nxt;
    logic [TW-1:0]       r_cnt,    w_cnt_nxt;
    logic [NUM_REQ-1:0]  r_run,    w_run_nxt;
    logic [NUM_REQ-1:0]  r_ack,    w_ack_nxt;
    logic                r_to,     w_to_nxt;
    logic [7:0]          r_x,      w_x_nxt;
    logic [6:0]          r_y,      w_y_nxt;
    logic [CW-1:0]       r_col,    w_col_nxt;
    logic                r_plot,   w_plot_nxt;

    logic [2*NUM_REQ-1:0] w_req_rot;
    logic                 w_found;
    logic [2:0]           w_pick;
    logic [3:0]           w_sum;

    logic [7:0]           w_sel_x;
    logic [6:0]           w_sel_y;
    logic [CW-1:0]        w_sel_col;
    logic                 w_sel_plot;
    logic                 w_sel_done;

    // Rotate req so that bit 0 is the engine at rr_ptr; the first set bit
    // then maps back to (rr_ptr + k) mod NUM_REQ.
    assign w_req_rot = {req, req} >> r_rr_ptr;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found = 1'b1;
                w_sum   = 4'(r_rr_ptr) + 4'(k);
                if (w_sum >= 4'(NUM_REQ)) begin
                    w_sum = w_sum - 4'(NUM_REQ);
                end
                w_pick  = w_sum[2:0];
            end
        end
    end

    always_comb begin
        w_sel_x    = '0;
        w_sel_y    = '0;
        w_sel_col  = '0;
        w_sel_plot = 1'b0;
        w_sel_done = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == 3'(i)) begin
                w_sel_x    = x_in[8*i +: 8];
                w_sel_y    = y_in[7*i +: 7];
                w_sel_col  = colour_in[CW*i +: CW];
                w_sel_plot = plot_in[i];
                w_sel_done = done[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_run_nxt   = r_run;
        w_ack_nxt   = '0;
        w_to_nxt    = 1'b0;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_col_nxt   = r_col;
        w_plot_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_run_nxt   = NUM_REQ'(1) << w_pick;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                w_x_nxt    = w_sel_x;
                w_y_nxt    = w_sel_y;
                w_col_nxt  = w_sel_col;
                w_plot_nxt = w_sel_plot;
                w_cnt_nxt  = r_cnt + TW'(1);
                // done takes priority over a watchdog expiry on the same cycle
                if (w_sel_done) begin
                    w_run_nxt   = '0;
                    w_ack_nxt   = NUM_REQ'(1) << r_grant;
                    w_state_nxt = S_RELEASE;
                end else if (r_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_run_nxt   = '0;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_rr_nxt    = (r_grant == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant + 3'd1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_run_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_run    <= '0;
            r_ack    <= '0;
            r_to     <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_col    <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_grant  <= w_grant_nxt;
            r_cnt    <= w_cnt_nxt;
            r_run    <= w_run_nxt;
            r_ack    <= w_ack_nxt;
            r_to     <= w_to_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_col    <= w_col_nxt;
            r_plot   <= w_plot_nxt;
        end
    end

    assign run         = r_run;
    assign done_ack    = r_ack;
    assign timeout_err = r_to;
    assign vga_x       = r_x;
    assign vga_y       = r_y;
    assign vga_colour  = r_col;
    assign vga_plot    = r_plot;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_grant;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
module tb_vga_draw_scheduler;
    localparam int N  = 4;
    localparam int T  = 4096;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    done = '0;
    logic [N-1:0]    plot_in = '0;
    logic [8*N-1:0]  x_in = '0;
    logic [7*N-1:0]  y_in = '0;
    logic [CW*N-1:0] colour_in = '0;
    logic [N-1:0]    run;
    logic [N-1:0]    done_ack;
    logic            timeout_err;
    logic [7:0]      vga_x;
    logic [6:0]      vga_y;
    logic [CW-1:0]   vga_colour;
    logic            vga_plot;
    logic            busy;
    logic [2:0]      grant_id;

    always #5 clk = ~clk;

    vga_draw_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .CW(CW)) dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done), .plot_in(plot_in),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .run(run),
        .done_ack(done_ack), .timeout_err(timeout_err), .vga_x(vga_x),
        .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .grant_id(grant_id)
    );

    // Engine behaviour: cycle 1 out of reset is silent (optionally with a
    // stale done), cycles 2..len+1 plot, done is raised from cycle len+2 on.
    int e_len[N];
    bit e_hang[N];
    bit e_stale[N];
    int e_bx[N];
    int e_by[N];
    int e_step[N];
    int e_cnt[N];

    always @(negedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (!run[i]) begin
                e_cnt[i]   = 0;
                plot_in[i] = 1'b0;
                done[i]    = 1'b0;
            end else begin
                e_cnt[i]   = e_cnt[i] + 1;
                plot_in[i] = (e_cnt[i] >= 2) && (e_cnt[i] <= e_len[i] + 1);
                done[i]    = (!e_hang[i] && e_cnt[i] >= e_len[i] + 2) || (e_stale[i] && e_cnt[i] == 1);
                x_in[8*i +: 8]        = 8'(e_bx[i] + e_step[i] * e_cnt[i]);
                y_in[7*i +: 7]        = 7'(e_by[i]);
                colour_in[CW*i +: CW] = CW'(e_cnt[i] * 7 + i * 37);
            end
        end
    end

    typedef struct {
        int id;
        bit ack;
        int lat;
        int plots;
    } comp_t;

    int    gq[$];
    comp_t cq[$];
    int    total = 0;
    int    bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on grants and completions
    int cyc = 0;
    int t0 = 0;
    int cur = 0;
    int plots = 0;
    int quiet = 0;
    int m_id;
    int m_ack_id;
    int m_exp;
    bit act = 1'b0;
    bit prev_busy = 1'b0;
    logic [N-1:0] prev_run = '0;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;
    int last_fall[N];
    comp_t m_c;

    initial for (int i = 0; i < N; i++) last_fall[i] = -100;

    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            check("rst_run", int'(run), 0);
            check("rst_plot", int'(vga_plot), 0);
            check("rst_x", int'(vga_x), 0);
            check("rst_y", int'(vga_y), 0);
            check("rst_colour", int'(vga_colour), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_grant_id", int'(grant_id), 0);
            check("rst_ack", int'(done_ack), 0);
            check("rst_timeout", int'(timeout_err), 0);
            act = 1'b0; prev_run = '0; prev_busy = 1'b0; quiet = 0;
        end else begin
            check("run_onehot", int'($countones(run) <= 1), 1);
            m_rise = run & ~prev_run;
            m_fall = prev_run & ~run;
            for (int i = 0; i < N; i++) if (m_fall[i]) last_fall[i] = cyc;
            if (m_rise != '0) begin
                quiet = 0;
                m_id = 0;
                for (int i = 0; i < N; i++) if (m_rise[i]) m_id = i;
                if (gq.size() == 0) begin
                    check("unexpected_grant", m_id, -1);
                end else begin
                    m_exp = gq.pop_front();
                    check("grant_order", m_id, m_exp);
                end
                check("grant_id_port", int'(grant_id), m_id);
                check("regrant_gap", int'(cyc - last_fall[m_id] >= 2), 1);
                check("busy_low_before_grant", int'(prev_busy), 0);
                check("busy_at_grant", int'(busy), 1);
                act = 1'b1; cur = m_id; t0 = cyc; plots = 0;
            end
            if (vga_plot) begin
                plots++;
                check("plot_owner", int'(act), 1);
                if (act) begin
                    check("pix_x", int'(vga_x), int'(x_in[8*cur +: 8]));
                    check("pix_y", int'(vga_y), int'(y_in[7*cur +: 7]));
                    check("pix_colour", int'(vga_colour), int'(colour_in[CW*cur +: CW]));
                end
            end
            if (done_ack != '0 || timeout_err) begin
                quiet = 0;
                m_ack_id = -1;
                for (int i = 0; i < N; i++) if (done_ack[i]) m_ack_id = i;
                check("ack_onehot", int'($countones(done_ack) <= 1), 1);
                if (cq.size() == 0) begin
                    check("unexpected_completion", m_ack_id, -2);
                end else begin
                    m_c = cq.pop_front();
                    check("comp_id", timeout_err ? cur : m_ack_id, m_c.id);
                    check("comp_is_ack", int'(done_ack != '0), int'(m_c.ack));
                    check("comp_is_timeout", int'(timeout_err), int'(!m_c.ack));
                    check("comp_latency", cyc - t0, m_c.lat);
                    check("comp_plot_count", plots, m_c.plots);
                    check("comp_busy", int'(busy), 1);
                end
                act = 1'b0;
            end
            if (cq.size() != 0) begin
                quiet++;
                if (quiet > T + 50) begin
                    check("stall_cycles", quiet, 0);
                    gq.delete(); cq.delete(); act = 1'b0; quiet = 0;
                end
            end
            prev_run = run;
            prev_busy = busy;
        end
    end

    // Stimulus and reference model
    int rr_m = 0;

    task automatic cfg(input int id, input int len, input bit hang, input bit stale,
                       input int bx, input int by, input int step);
        e_len[id] = len; e_hang[id] = hang; e_stale[id] = stale;
        e_bx[id] = bx; e_by[id] = by; e_step[id] = step;
    endtask

    // All engines in mask request together; they are served in ascending
    // distance from the pointer and each finishes before the next starts.
    task automatic run_phase(input logic [N-1:0] mask);
        int id;
        int last;
        int n;
        int budget;
        comp_t c;
        logic [N-1:0] pr;
        last = rr_m;
        for (int k = 0; k < N; k++) begin
            id = (rr_m + k) % N;
            if (mask[id]) begin
                gq.push_back(id);
                c.id    = id;
                c.ack   = !e_hang[id] && (e_len[id] <= T - 1);
                c.lat   = c.ack ? e_len[id] + 2 : T + 1;
                c.plots = c.ack ? e_len[id] : ((e_len[id] < T) ? e_len[id] : T);
                cq.push_back(c);
                last = (id + 1) % N;
            end
        end
        rr_m = last;
        @(negedge clk); #2;
        req = req | mask;
        pr = run;
        n = 0;
        budget = $countones(mask) * (T + 20) + 100;
        while ((cq.size() != 0 || busy) && n < budget) begin
            @(negedge clk); #2;
            for (int i = 0; i < N; i++) if (pr[i] && !run[i]) req[i] = 1'b0;
            pr = run;
            n++;
        end
        if (n >= budget) begin
            $display("FAIL phase_budget actual=%0d required<%0d", n, budget);
            $fatal(1, "scheduler stuck");
        end
    endtask

    initial begin
        logic [N-1:0] mask;
        int n;
        for (int i = 0; i < N; i++) cfg(i, 10, 1'b0, 1'b0, 10 * i, i, 1);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #3 resetn = 1'b1;

        // round robin 0,1,2,3 then 0 again
        run_phase(4'b1111);
        run_phase(4'b0001);

        // single long draw
        cfg(0, 3200, 1'b0, 1'b0, 3, 5, 1);
        run_phase(4'b0001);

        // watchdog on engine 2, engine 3 waiting behind it
        cfg(2, 1000000, 1'b1, 1'b0, 7, 9, 3);
        cfg(3, 8, 1'b0, 1'b0, 100, 60, 2);
        run_phase(4'b1100);

        // done on the last watchdog cycle wins; one later times out
        cfg(3, T - 1, 1'b0, 1'b0, 1, 2, 1);
        run_phase(4'b1000);
        cfg(1, T, 1'b0, 1'b0, 4, 3, 1);
        run_phase(4'b0010);

        // stale done during the first cycle out of reset
        cfg(1, 5, 1'b0, 1'b1, 20, 30, 1);
        run_phase(4'b0010);

        // reset in the middle of a draw
        cfg(2, 300, 1'b0, 1'b0, 50, 20, 0);
        gq.push_back(2);
        @(negedge clk); #2;
        req[2] = 1'b1;
        n = 0;
        while (!run[2] && n < 50) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        #3 resetn = 1'b0;
        req = '0;
        @(negedge clk);
        #3 resetn = 1'b1;
        rr_m = 0;
        run_phase(4'b0000);
        cfg(0, 7, 1'b0, 1'b0, 11, 12, 1);
        cfg(3, 9, 1'b0, 1'b0, 13, 14, 1);
        run_phase(4'b1001);

        // randomized phases
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                cfg(i, int'($urandom_range(0, 40)), 1'b0, 1'(($urandom_range(0, 3)) == 0),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 5)));
            end
            mask = 4'($urandom_range(1, 15));
            run_phase(mask);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
